simt_branch_unit: RTL and testbench

- Per-warp control-flow stage directly downstream of the lane ALUs.
- Consumes the per-lane compare results produced for BEQ/BNE/BLT/BGE, together with the decoded PC, target and reconvergence PC.
- Produces the warp's next fetch PC and active thread mask.
- Divergence is handled with a hardware reconvergence stack; every retiring instruction passes through this unit.

---
 rtl/simt_branch_unit.sv | 146 ++++++++++++++
 tb/tb_simt_branch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/simt_branch_unit.sv
// Per-warp branch resolution: picks the next fetch PC and lane mask, splitting divergent
// warps onto a reconvergence stack and popping entries as their reconvergence PC is reached.
`timescale 1ns/1ps
module simt_branch_unit #(
   parameter int THREADS     = 4,
   parameter int ADDR_WIDTH  = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               valid,
   output logic                               ready,
   input  logic                               is_branch,
   input  logic                               is_jump,
   input  logic [ADDR_WIDTH-1:0]              pc,
   input  logic [ADDR_WIDTH-1:0]              target,
   input  logic [ADDR_WIDTH-1:0]              reconv_pc,
   input  logic [THREADS-1:0]                 cond,
   output logic [ADDR_WIDTH-1:0]              next_pc,
   output logic [THREADS-1:0]                 active_mask,
   output logic                               done,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
   output logic                               overflow
);
   localparam int DW    = $clog2(STACK_DEPTH + 1);
   localparam int IW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int SLOTS = 1 << IW;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] EVAL  = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;

   logic [1:0]            state;
   logic                  br_r;
   logic                  jp_r;
   logic [ADDR_WIDTH-1:0] pc_r;
   logic [ADDR_WIDTH-1:0] tgt_r;
   logic [ADDR_WIDTH-1:0] rpc_r;
   logic [THREADS-1:0]    cond_r;
   logic [ADDR_WIDTH-1:0] cand_pc;
   logic [THREADS-1:0]    cand_mask;

   logic [ADDR_WIDTH-1:0] stk_rpc  [SLOTS];
   logic [ADDR_WIDTH-1:0] stk_pc   [SLOTS];
   logic [THREADS-1:0]    stk_mask [SLOTS];

   logic [THREADS-1:0]    taken;
   logic [ADDR_WIDTH-1:0] seq_pc;
   logic                  divergent;
   logic                  room;
   logic                  pop_hit;
   logic [IW-1:0]         push_ix;
   logic [IW-1:0]         top_ix;
   logic [ADDR_WIDTH-1:0] eval_pc;
   logic [THREADS-1:0]    eval_mask;

   assign ready     = (state == IDLE);
   assign taken     = cond_r & active_mask;
   assign seq_pc    = pc_r + ADDR_WIDTH'(1);
   assign divergent = br_r && (taken != '0) && (taken != active_mask);
   assign room      = (int'(depth) + 2) <= STACK_DEPTH;
   assign push_ix   = IW'(depth);
   assign top_ix    = IW'(depth - DW'(1));
   assign pop_hit   = (depth != '0) && (cand_pc == stk_rpc[top_ix]);

   // Divergence without room keeps the whole warp together on the taken path.
   always_comb begin
      eval_pc   = seq_pc;
      eval_mask = active_mask;
      if (br_r) begin
         if (taken != '0) begin
            eval_pc = tgt_r;
            if (divergent && room)
               eval_mask = taken;
         end
      end else if (jp_r) begin
         eval_pc = tgt_r;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         next_pc     <= '0;
         active_mask <= '1;
         done        <= 1'b0;
         depth       <= '0;
         overflow    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE:
               if (valid)
                  state <= EVAL;
            EVAL: begin
               state <= CHECK;
               if (divergent) begin
                  if (room)
                     depth <= depth + DW'(2);
                  else
                     overflow <= 1'b1;
               end
            end
            CHECK:
               if (pop_hit) begin
                  depth <= depth - DW'(1);
               end else begin
                  next_pc     <= cand_pc;
                  active_mask <= cand_mask;
                  done        <= 1'b1;
                  state       <= IDLE;
               end
            default:
               state <= IDLE;
         endcase
      end
   end

   // Operand latch, candidate and stack storage carry no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && valid) begin
         br_r   <= is_branch;
         jp_r   <= is_jump;
         pc_r   <= pc;
         tgt_r  <= target;
         rpc_r  <= reconv_pc;
         cond_r <= cond;
      end
      if (state == EVAL) begin
         cand_pc   <= eval_pc;
         cand_mask <= eval_mask;
         if (divergent && room) begin
            stk_rpc[push_ix]             <= rpc_r;
            stk_pc[push_ix]              <= rpc_r;
            stk_mask[push_ix]            <= active_mask;
            stk_rpc[push_ix + IW'(1)]    <= rpc_r;
            stk_pc[push_ix + IW'(1)]     <= seq_pc;
            stk_mask[push_ix + IW'(1)]   <= active_mask & ~taken;
         end
      end
      if (state == CHECK && pop_hit) begin
         cand_pc   <= stk_pc[top_ix];
         cand_mask <= stk_mask[top_ix];
      end
   end
endmodule

// File: tb/tb_simt_branch_unit.sv
// Bench for simt_branch_unit: a deep (4) and a shallow (2) stack instance share stimulus and
// are compared against a stack-of-entries reference model, directed cases first, then random.
`timescale 1ns/1ps
module tb_simt_branch_unit;
   logic       clk = 1'b0;
   logic       reset;
   logic       valid;
   logic       is_branch;
   logic       is_jump;
   logic [7:0] pc;
   logic [7:0] target;
   logic [7:0] reconv_pc;
   logic [3:0] cond;

   logic       ready,   s_ready;
   logic [7:0] next_pc, s_next_pc;
   logic [3:0] active_mask, s_active_mask;
   logic       done,    s_done;
   logic [2:0] depth;
   logic [1:0] s_depth;
   logic       overflow, s_overflow;

   always #5 clk = ~clk;

   simt_branch_unit #(.THREADS(4), .ADDR_WIDTH(8), .STACK_DEPTH(4)) u_dut (
      .clk(clk), .reset(reset), .valid(valid), .ready(ready),
      .is_branch(is_branch), .is_jump(is_jump), .pc(pc), .target(target),
      .reconv_pc(reconv_pc), .cond(cond), .next_pc(next_pc),
      .active_mask(active_mask), .done(done), .depth(depth), .overflow(overflow)
   );

   simt_branch_unit #(.THREADS(4), .ADDR_WIDTH(8), .STACK_DEPTH(2)) u_small (
      .clk(clk), .reset(reset), .valid(valid), .ready(s_ready),
      .is_branch(is_branch), .is_jump(is_jump), .pc(pc), .target(target),
      .reconv_pc(reconv_pc), .cond(cond), .next_pc(s_next_pc),
      .active_mask(s_active_mask), .done(s_done), .depth(s_depth), .overflow(s_overflow)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state, index 0 = deep instance, 1 = shallow instance.
   logic [7:0] m_rpc  [2][8];
   logic [7:0] m_pc   [2][8];
   logic [3:0] m_mask [2][8];
   int         m_dep  [2];
   logic [3:0] m_act  [2];
   logic [7:0] m_npc  [2];
   logic       m_ovf  [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_dep[k] = 0;
         m_act[k] = 4'hF;
         m_npc[k] = 8'd0;
         m_ovf[k] = 1'b0;
      end
   endtask

   task automatic model_step(input int k, input bit br, input bit jp, input logic [7:0] p,
                             input logic [7:0] t, input logic [7:0] r, input logic [3:0] c,
                             output int pops);
      int         sd;
      logic [3:0] a, tk, msk;
      logic [7:0] nxt, cand;
      sd   = (k == 0) ? 4 : 2;
      a    = m_act[k];
      tk   = c & a;
      nxt  = p + 8'd1;
      cand = nxt;
      msk  = a;
      if (br) begin
         if (tk == 4'd0) cand = nxt;
         else if (tk == a) cand = t;
         else if (m_dep[k] + 2 <= sd) begin
            m_rpc[k][m_dep[k]] = r; m_pc[k][m_dep[k]] = r;   m_mask[k][m_dep[k]] = a;
            m_rpc[k][m_dep[k]+1] = r; m_pc[k][m_dep[k]+1] = nxt; m_mask[k][m_dep[k]+1] = a & ~tk;
            m_dep[k] += 2;
            cand = t;
            msk  = tk;
         end else begin
            m_ovf[k] = 1'b1;
            cand = t;
         end
      end else if (jp) begin
         cand = t;
      end
      pops = 0;
      while (m_dep[k] > 0 && m_rpc[k][m_dep[k]-1] == cand) begin
         cand = m_pc[k][m_dep[k]-1];
         msk  = m_mask[k][m_dep[k]-1];
         m_dep[k]--;
         pops++;
      end
      m_npc[k] = cand;
      m_act[k] = msk;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_npc"},   next_pc,     0);   chk({tag, "_s_npc"},  s_next_pc,     0);
      chk({tag, "_mask"},  active_mask, 4'hF); chk({tag, "_s_mask"}, s_active_mask, 4'hF);
      chk({tag, "_ready"}, {ready, s_ready}, 2'b11);
      chk({tag, "_done"},  {done, s_done},   2'b00);
      chk({tag, "_depth"}, depth, 0);      chk({tag, "_s_depth"}, s_depth, 0);
      chk({tag, "_ovf"},   {overflow, s_overflow}, 2'b00);
   endtask

   task automatic txn(input bit br, input bit jp, input logic [7:0] p, input logic [7:0] t,
                      input logic [7:0] r, input logic [3:0] c);
      int pops0, pops1;
      int lat0 = 0, lat1 = 0;
      model_step(0, br, jp, p, t, r, c, pops0);
      model_step(1, br, jp, p, t, r, c, pops1);
      chk("ready_pre", {ready, s_ready}, 2'b11);
      is_branch = br; is_jump = jp; pc = p; target = t; reconv_pc = r; cond = c;
      valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      chk("busy", {ready, s_ready, done, s_done}, 4'b0000);
      for (int cyc = 1; cyc <= 24 && (lat0 == 0 || lat1 == 0); cyc++) begin
         @(posedge clk);
         #1;
         if (done && lat0 == 0) lat0 = cyc;
         if (s_done && lat1 == 0) lat1 = cyc;
      end
      chk("latency",   lat0, 2 + pops0);
      chk("s_latency", lat1, 2 + pops1);
      chk("next_pc",   next_pc,       m_npc[0]);
      chk("s_next_pc", s_next_pc,     m_npc[1]);
      chk("mask",      active_mask,   m_act[0]);
      chk("s_mask",    s_active_mask, m_act[1]);
      chk("depth",     depth,         m_dep[0]);
      chk("s_depth",   s_depth,       m_dep[1]);
      chk("ovf",       overflow,      m_ovf[0]);
      chk("s_ovf",     s_overflow,    m_ovf[1]);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      is_branch = 0; is_jump = 0; pc = 0; target = 0; reconv_pc = 0; cond = 0;
      model_reset();
      do_reset();
      check_reset_state("rst");

      txn(0, 0, 8'd5, 8'd0, 8'd0, 4'h0);     chk("plan_seq", next_pc, 8'd6);
      txn(0, 0, 8'd255, 8'd0, 8'd0, 4'h0);   chk("plan_wrap", next_pc, 8'd0);
      txn(1, 0, 8'd3, 8'd10, 8'd0, 4'hF);    chk("plan_taken", next_pc, 8'd10);
      txn(1, 0, 8'd3, 8'd10, 8'd0, 4'h0);    chk("plan_fall", next_pc, 8'd4);
      txn(1, 0, 8'd4, 8'd8, 8'd12, 4'b0011);
      chk("plan_div_mask", active_mask, 4'b0011); chk("plan_div_depth", depth, 3'd2);
      txn(0, 0, 8'd11, 8'd0, 8'd0, 4'h0);
      chk("plan_pop_pc", next_pc, 8'd5);     chk("plan_pop_mask", active_mask, 4'b1100);
      txn(0, 0, 8'd11, 8'd0, 8'd0, 4'h0);
      chk("plan_join_pc", next_pc, 8'd12);   chk("plan_join_mask", active_mask, 4'hF);
      txn(1, 0, 8'd4, 8'd8, 8'd12, 4'b0011);
      txn(1, 0, 8'd8, 8'd9, 8'd11, 4'b0001);
      chk("plan_ovf", s_overflow, 1'b1);     chk("plan_ovf_mask", s_active_mask, 4'b0011);
      chk("plan_ovf_pc", s_next_pc, 8'd9);   chk("plan_ovf_depth", s_depth, 2'd2);
      txn(1, 1, 8'd20, 8'd30, 8'd40, 4'hF);  chk("plan_br_wins", next_pc, 8'd30);

      for (int n = 0; n < 400; n++) begin
         if (n == 200) do_reset();
         txn($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
             ($urandom_range(0, 19) == 0) ? 8'd255 : 8'($urandom_range(0, 15)),
             8'($urandom_range(0, 15)),
             ($urandom_range(0, 1) == 1) ? 8'd12 : 8'd9,
             4'($urandom));
      end

      do_reset();
      txn(1, 0, 8'd4, 8'd8, 8'd12, 4'b0011);
      is_branch = 0; is_jump = 0; pc = 8'd11; valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_state("midrst");
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      chk("midrst_nodone", {done, s_done, ready, s_ready}, 4'b0011);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
